sdram_rw_arbiter: RTL and testbench
===================================

Name: sdram_rw_arbiter

Overview:
Burst scheduler that sits in front of the SDRAM top-level controller and shares it between a write-path FIFO (camera/source side) and a read-path FIFO (display/sink side). It decides when a burst is due, drives write_req/read_req with a stable sdram_addr and sys_bank, and waits for the burst-end ack. It also keeps independent circular write and read frame pointers. Refresh arbitration stays inside the SDRAM controller; this block only sequences user bursts.

Parameters:
BURST_LEN, 256, words per burst; equals the controller burst length; power of two.
FRAME_WORDS, 307200, words per frame; must be a multiple of BURST_LEN and no greater than 2^20.
FIFO_AW, 10, FIFO address width; FIFO depth = 2^FIFO_AW, which must be at least BURST_LEN.

Ports:
S_CLK  in  1  system clock; all logic on rising edge.
RST  in  1  synchronous, active-high reset.
wr_fifo_usedw  in  FIFO_AW+1  words currently held in the write-path FIFO.
rd_fifo_usedw  in  FIFO_AW+1  words currently held in the read-path FIFO.
rd_enable  in  1  sink wants the read stream; level.
write_ack  in  1  one-cycle pulse: SDRAM write burst finished.
read_ack  in  1  one-cycle pulse: SDRAM read burst finished.
write_req  out  1  write burst request; registered.
read_req  out  1  read burst request; registered.
sdram_addr  out  20  burst start address; registered.
sys_bank  out  2  burst bank; registered.
frame_done  out  1  one-cycle pulse when a write frame completes.
busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock domain (S_CLK); reset synchronous, active-high (RST). RST sampled high forces every register to its reset value at that edge, even mid-burst.
- Reset values: write_req=0, read_req=0, sdram_addr=0, sys_bank=0, frame_done=0, busy=0. Internal: wr_ptr=0, rd_ptr=0, frame_valid=0, last_grant=READ (so write wins the first tie), state=IDLE.
- Eligibility, evaluated in IDLE only:
  - wr_elig = (wr_fifo_usedw >= BURST_LEN).
  - rd_elig = rd_enable & frame_valid & ((2^FIFO_AW - rd_fifo_usedw) >= BURST_LEN).
- State machine: IDLE, WR, RD, GAP.
  - IDLE, one eligible: grant it.
  - IDLE, both eligible: grant the opposite of last_grant (round-robin).
  - IDLE, none eligible: stay in IDLE.
  - Grant to WR: next edge write_req=1, sdram_addr=wr_ptr, sys_bank=wr_bank, last_grant=WRITE. Grant to RD is symmetric. Latency from eligibility sampled to req high is 1 cycle.
  - WR: hold write_req, sdram_addr and sys_bank constant until write_ack is sampled high. At that edge: write_req=0; wr_ptr += BURST_LEN, or wr_ptr=0 if the sum equals FRAME_WORDS. On that wrap, frame_done pulses and frame_valid=1. Go to GAP.
  - RD: same as WR using read_ack, rd_ptr and read_req; no frame_done pulse.
  - GAP: one cycle so FIFO usedw settles, then IDLE. Minimum request-to-request spacing is 3 cycles after an ack.
- An ack arriving in a state that does not match it (for example read_ack in IDLE or WR) is ignored, with no pointer change.
- write_req and read_req are never high together.
- Requests never drop before their ack. The controller handles refresh, so an ack may arrive any number of cycles later; there is no timeout.
- Pointer arithmetic is 20-bit unsigned; wrap is by compare to FRAME_WORDS, never by overflow.
- rd_enable falling while in RD does not abort the burst; it only blocks new read grants.

Optional Feature:
SDRAM_ARB_PINGPONG_EN
- Defined: double-buffered frames.
  - wr_bank starts at 0 and toggles 0↔1 on every write-frame wrap. last_done_bank latches the bank just completed.
  - rd_bank is reloaded from last_done_bank whenever a read grant is issued with rd_ptr==0, so reads never touch the bank being written.
  - sys_bank = {1'b0, wr_bank} or {1'b0, rd_bank}.
- Undefined: wr_bank = rd_bank = 0 and sys_bank is always 2'b00. Reads and writes share one frame buffer; tearing is acceptable.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, FIFOs empty → all outputs 0 and no req for 100 cycles.
- Single write: wr_fifo_usedw=256 → write_req high 1 cycle later with sdram_addr=0, sys_bank=0. Ack after 300 cycles → req low next edge, next write at addr 256.
- Read gating and tie: set rd_enable=1 and rd_fifo_usedw=0 before any frame → no read_req. Complete 1200 write bursts → frame_done pulses once and wr_ptr returns to 0. Then with both eligible → grants alternate W, R, W, R, and read addrs run 0, 256, 512.
- Ack hygiene: pulse read_ack during a write burst → ignored; rd_ptr unchanged and write_req held.
- Reset mid-burst: RST during WR with write_req=1 → write_req=0, pointers 0 and frame_valid=0 after that edge.
- PINGPONG_EN: after frame 1, writes use bank 1 and reads use bank 0. After frame 2, a read frame starting at rd_ptr=0 uses bank 1.

Source files
------------

// File: rtl/sdram_rw_arbiter.sv
// sdram_rw_arbiter
//   Burst scheduler in front of the SDRAM controller. It shares the controller
//   between a write-path FIFO (source) and a read-path FIFO (sink), issues one
//   burst request at a time with a stable address/bank, and waits for the
//   controller's burst-end ack. It keeps circular write and read frame pointers.
//
//   Optional macro SDRAM_ARB_PINGPONG_EN: double-buffered frames. Writes flip
//   between bank 0 and bank 1 on every frame wrap. A read frame (rd_ptr==0 at
//   grant) starts on the bank most recently completed. With the macro undefined,
//   everything uses bank 0.
//
// Ports
//   S_CLK          in   system clock, rising edge
//   RST            in   synchronous active-high reset
//   wr_fifo_usedw  in   words held in the write-path FIFO
//   rd_fifo_usedw  in   words held in the read-path FIFO
//   rd_enable      in   sink wants the read stream (level)
//   write_ack      in   write burst finished (pulse)
//   read_ack       in   read burst finished (pulse)
//   write_req      out  write burst request (registered)
//   read_req       out  read burst request (registered)
//   sdram_addr     out  burst start address (registered)
//   sys_bank       out  burst bank (registered)
//   frame_done     out  one-cycle pulse when a write frame completes
//   busy           out  state machine is not in IDLE
module sdram_rw_arbiter #(
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_AW     = 10
) (
  input  logic               S_CLK,
  input  logic               RST,
  input  logic [FIFO_AW:0]   wr_fifo_usedw,
  input  logic [FIFO_AW:0]   rd_fifo_usedw,
  input  logic               rd_enable,
  input  logic               write_ack,
  input  logic               read_ack,
  output logic               write_req,
  output logic               read_req,
  output logic [19:0]        sdram_addr,
  output logic [1:0]         sys_bank,
  output logic               frame_done,
  output logic               busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] WR_MIN    = (FIFO_AW+1)'(BURST_LEN);
  // Read is eligible when free space (DEPTH - usedw) >= BURST_LEN.
  localparam logic [FIFO_AW:0] RD_MAX    = (FIFO_AW+1)'(DEPTH - BURST_LEN);
  // 21-bit sums so that FRAME_WORDS == 2^20 still compares correctly.
  localparam logic [20:0]      BURST_INC = 21'(BURST_LEN);
  localparam logic [20:0]      FRAME_END = 21'(FRAME_WORDS);

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_GAP} state_e;

  state_e      state_q, state_d;
  logic [19:0] wr_ptr_q, wr_ptr_d;
  logic [19:0] rd_ptr_q, rd_ptr_d;
  logic        frame_valid_q, frame_valid_d;
  logic        last_grant_q, last_grant_d;
  logic        write_req_q, write_req_d;
  logic        read_req_q, read_req_d;
  logic [19:0] sdram_addr_q, sdram_addr_d;
  logic [1:0]  sys_bank_q, sys_bank_d;
  logic        frame_done_q, frame_done_d;

  logic        wr_elig, rd_elig, grant_wr, grant_rd;
  logic [20:0] wr_sum, rd_sum;
  logic        wr_wrap, rd_wrap;
  logic        wr_bank, rd_grant_bank;

`ifdef SDRAM_ARB_PINGPONG_EN
  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;
  logic last_done_bank_q, last_done_bank_d;

  assign wr_bank       = wr_bank_q;
  // A new read frame picks up the bank that was finished most recently.
  assign rd_grant_bank = (rd_ptr_q == 20'd0) ? last_done_bank_q : rd_bank_q;
`else
  assign wr_bank       = 1'b0;
  assign rd_grant_bank = 1'b0;
`endif

  assign wr_elig = (wr_fifo_usedw >= WR_MIN);
  assign rd_elig = rd_enable && frame_valid_q && (rd_fifo_usedw <= RD_MAX);

  // Round-robin on a tie: the side that did not go last wins.
  assign grant_wr = wr_elig && (!rd_elig || (last_grant_q == GRANT_RD));
  assign grant_rd = rd_elig && !grant_wr;

  assign wr_sum  = {1'b0, wr_ptr_q} + BURST_INC;
  assign rd_sum  = {1'b0, rd_ptr_q} + BURST_INC;
  assign wr_wrap = (wr_sum == FRAME_END);
  assign rd_wrap = (rd_sum == FRAME_END);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    frame_valid_d = frame_valid_q;
    last_grant_d  = last_grant_q;
    write_req_d   = write_req_q;
    read_req_d    = read_req_q;
    sdram_addr_d  = sdram_addr_q;
    sys_bank_d    = sys_bank_q;
    frame_done_d  = 1'b0;
`ifdef SDRAM_ARB_PINGPONG_EN
    wr_bank_d        = wr_bank_q;
    rd_bank_d        = rd_bank_q;
    last_done_bank_d = last_done_bank_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant_wr) begin
          write_req_d  = 1'b1;
          sdram_addr_d = wr_ptr_q;
          sys_bank_d   = {1'b0, wr_bank};
          last_grant_d = GRANT_WR;
          state_d      = S_WR;
        end else if (grant_rd) begin
          read_req_d   = 1'b1;
          sdram_addr_d = rd_ptr_q;
          sys_bank_d   = {1'b0, rd_grant_bank};
          last_grant_d = GRANT_RD;
          state_d      = S_RD;
`ifdef SDRAM_ARB_PINGPONG_EN
          rd_bank_d    = rd_grant_bank;
`endif
        end
      end
      S_WR: begin
        // Only write_ack ends a write burst; read_ack here is ignored.
        if (write_ack) begin
          write_req_d = 1'b0;
          state_d     = S_GAP;
          if (wr_wrap) begin
            wr_ptr_d      = 20'd0;
            frame_done_d  = 1'b1;
            frame_valid_d = 1'b1;
`ifdef SDRAM_ARB_PINGPONG_EN
            last_done_bank_d = wr_bank_q;
            wr_bank_d        = ~wr_bank_q;
`endif
          end else begin
            wr_ptr_d = wr_sum[19:0];
          end
        end
      end
      S_RD: begin
        if (read_ack) begin
          read_req_d = 1'b0;
          state_d    = S_GAP;
          rd_ptr_d   = rd_wrap ? 20'd0 : rd_sum[19:0];
        end
      end
      // One idle cycle so the FIFO fill levels reflect the finished burst.
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge S_CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= 20'd0;
      rd_ptr_q      <= 20'd0;
      frame_valid_q <= 1'b0;
      last_grant_q  <= GRANT_RD;
      write_req_q   <= 1'b0;
      read_req_q    <= 1'b0;
      sdram_addr_q  <= 20'd0;
      sys_bank_q    <= 2'd0;
      frame_done_q  <= 1'b0;
`ifdef SDRAM_ARB_PINGPONG_EN
      wr_bank_q        <= 1'b0;
      rd_bank_q        <= 1'b0;
      last_done_bank_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_valid_q <= frame_valid_d;
      last_grant_q  <= last_grant_d;
      write_req_q   <= write_req_d;
      read_req_q    <= read_req_d;
      sdram_addr_q  <= sdram_addr_d;
      sys_bank_q    <= sys_bank_d;
      frame_done_q  <= frame_done_d;
`ifdef SDRAM_ARB_PINGPONG_EN
      wr_bank_q        <= wr_bank_d;
      rd_bank_q        <= rd_bank_d;
      last_done_bank_q <= last_done_bank_d;
`endif
    end
  end

  assign write_req  = write_req_q;
  assign read_req   = read_req_q;
  assign sdram_addr = sdram_addr_q;
  assign sys_bank   = sys_bank_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Directed bench for sdram_rw_arbiter with default parameters.
module tb_sdram_rw_arbiter;

  localparam int FIFO_AW = 10;

  logic              S_CLK = 1'b0;
  logic              RST;
  logic [FIFO_AW:0]  wr_fifo_usedw, rd_fifo_usedw;
  logic              rd_enable, write_ack, read_ack;
  logic              write_req, read_req;
  logic [19:0]       sdram_addr;
  logic [1:0]        sys_bank;
  logic              frame_done, busy;

  int checks = 0;
  int errors = 0;

`ifdef SDRAM_ARB_PINGPONG_EN
  localparam logic [1:0] WB1 = 2'd1;  // write bank during frame 2
`else
  localparam logic [1:0] WB1 = 2'd0;
`endif

  sdram_rw_arbiter #(.BURST_LEN(256), .FRAME_WORDS(307200), .FIFO_AW(FIFO_AW)) dut (
    .S_CLK(S_CLK), .RST(RST),
    .wr_fifo_usedw(wr_fifo_usedw), .rd_fifo_usedw(rd_fifo_usedw),
    .rd_enable(rd_enable), .write_ack(write_ack), .read_ack(read_ack),
    .write_req(write_req), .read_req(read_req),
    .sdram_addr(sdram_addr), .sys_bank(sys_bank),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 S_CLK = ~S_CLK;

  task automatic tick(input int n);
    repeat (n) begin @(posedge S_CLK); #1; end
  endtask

  task automatic do_reset();
    RST = 1'b1; wr_fifo_usedw = '0; rd_fifo_usedw = '0;
    rd_enable = 1'b0; write_ack = 1'b0; read_ack = 1'b0;
    tick(2);
    RST = 1'b0;
  endtask

  // Waits (bounded) for a request, optionally pulses the wrong ack first,
  // then acks it. Reports what was granted and how the DUT behaved.
  task automatic serve(input bit spur, output bit ok, output bit is_wr,
                       output logic [19:0] addr, output logic [1:0] bank,
                       output bit held, output bit dropped, output bit fd);
    ok = 0; is_wr = 0; addr = '0; bank = '0; held = 1; dropped = 0; fd = 0;
    for (int i = 0; i < 50; i++) begin
      if (write_req || read_req) begin ok = 1; break; end
      tick(1);
    end
    if (!ok) return;
    is_wr = write_req; addr = sdram_addr; bank = sys_bank;
    if (spur) begin
      if (is_wr) read_ack = 1'b1; else write_ack = 1'b1;
      tick(1);
      read_ack = 1'b0; write_ack = 1'b0;
      tick(2);
      held = (write_req == is_wr) && (read_req == !is_wr) &&
             (sdram_addr == addr) && (sys_bank == bank);
    end
    if (is_wr) write_ack = 1'b1; else read_ack = 1'b1;
    tick(1);
    write_ack = 1'b0; read_ack = 1'b0;
    dropped = !write_req && !read_req;
    fd = frame_done;
  endtask

  task automatic test_reset();
    int bad;
    RST = 1'b1; wr_fifo_usedw = '0; rd_fifo_usedw = '0;
    rd_enable = 1'b0; write_ack = 1'b0; read_ack = 1'b0;
    tick(2);
    checks++;
    if ({write_req, read_req, sdram_addr, sys_bank, frame_done, busy} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b rd=%b addr=%0d bank=%0d fd=%b busy=%b, expected all 0",
               write_req, read_req, sdram_addr, sys_bank, frame_done, busy);
    end
    RST = 1'b0;
    bad = 0;
    repeat (100) begin
      tick(1);
      if (write_req || read_req || busy || frame_done) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_single_write();
    int bad;
    do_reset();
    wr_fifo_usedw = 11'd255;
    tick(5);
    checks++;
    if (write_req !== 1'b0) begin
      errors++;
      $display("FAIL wr_below_burst: got write_req=%b, expected 0", write_req);
    end
    wr_fifo_usedw = 11'd256;
    tick(1);
    checks++;
    if (write_req !== 1'b1 || read_req !== 1'b0 || sdram_addr !== 20'd0 ||
        sys_bank !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_write_grant: got wr=%b rd=%b addr=%0d bank=%0d busy=%b, expected 1 0 0 0 1",
               write_req, read_req, sdram_addr, sys_bank, busy);
    end
    // Fill level drops mid-burst: the request must still be held.
    wr_fifo_usedw = 11'd0;
    bad = 0;
    repeat (299) begin
      tick(1);
      if (write_req !== 1'b1 || sdram_addr !== 20'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL write_hold: got %0d cycles dropped/moved, expected 0", bad);
    end
    wr_fifo_usedw = 11'd256;
    write_ack = 1'b1;
    tick(1);
    write_ack = 1'b0;
    checks++;
    if (write_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ack_drop: got wr=%b busy=%b, expected 0 1", write_req, busy);
    end
    tick(1);
    checks++;
    if (write_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_cycle: got wr=%b busy=%b, expected 0 0", write_req, busy);
    end
    tick(1);
    checks++;
    if (write_req !== 1'b1 || sdram_addr !== 20'd256) begin
      errors++;
      $display("FAIL second_write: got wr=%b addr=%0d, expected 1 256", write_req, sdram_addr);
    end
    wr_fifo_usedw = 11'd0;
    write_ack = 1'b1; tick(1); write_ack = 1'b0;
    tick(2);
  endtask

  task automatic test_frame();
    bit ok, is_wr, held, dropped, fd, last_fd;
    logic [19:0] addr;
    logic [1:0] bank;
    int bad, fdn;
    do_reset();
    rd_enable = 1'b1;
    rd_fifo_usedw = 11'd0;
    tick(10);
    checks++;
    if (read_req !== 1'b0) begin
      errors++;
      $display("FAIL read_before_frame: got read_req=%b, expected 0", read_req);
    end
    // 769 words leave 255 free: one short of a burst.
    rd_fifo_usedw = 11'd769;
    wr_fifo_usedw = 11'd256;
    bad = 0; fdn = 0; last_fd = 0;
    for (int i = 0; i < 1200; i++) begin
      serve(1'b0, ok, is_wr, addr, bank, held, dropped, fd);
      if (!ok || !is_wr || addr !== 20'(i * 256) || bank !== 2'd0 || !dropped) bad++;
      if (fd) fdn++;
      if (i == 1199) last_fd = fd;
    end
    wr_fifo_usedw = 11'd0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL frame_writes: got %0d bad bursts, expected 0", bad);
    end
    checks++;
    if (fdn !== 1 || last_fd !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_count: got %0d pulses (last=%b), expected 1 (last=1)", fdn, last_fd);
    end
    tick(1);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_width: got %b one cycle later, expected 0", frame_done);
    end
    tick(10);
    checks++;
    if (read_req !== 1'b0 || write_req !== 1'b0) begin
      errors++;
      $display("FAIL rd_room_boundary: got rd=%b wr=%b with 255 free, expected 0 0", read_req, write_req);
    end
    rd_fifo_usedw = 11'd768;
    serve(1'b0, ok, is_wr, addr, bank, held, dropped, fd);
    checks++;
    if (!ok || is_wr || addr !== 20'd0 || bank !== 2'd0 || !dropped) begin
      errors++;
      $display("FAIL first_read: got ok=%b wr=%b addr=%0d bank=%0d, expected 1 0 0 0", ok, is_wr, addr, bank);
    end
  endtask

  // Continues from test_frame: both sides eligible, alternation plus stray acks.
  task automatic test_tie_ack_hygiene();
    bit ok, is_wr, held, dropped, fd;
    logic [19:0] addr;
    logic [1:0] bank;
    bit          exp_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [19:0] exp_a [4] = '{20'd0, 20'd256, 20'd256, 20'd512};
    logic [1:0]  exp_b [4] = '{WB1, 2'd0, WB1, 2'd0};
    wr_fifo_usedw = 11'd256;
    for (int k = 0; k < 4; k++) begin
      serve(k < 2, ok, is_wr, addr, bank, held, dropped, fd);
      checks++;
      if (!ok || is_wr !== exp_w[k] || addr !== exp_a[k] || bank !== exp_b[k] || !held || !dropped) begin
        errors++;
        $display("FAIL tie_grant%0d: got ok=%b wr=%b addr=%0d bank=%0d held=%b dropped=%b, expected 1 %b %0d %0d 1 1",
                 k, ok, is_wr, addr, bank, held, dropped, exp_w[k], exp_a[k], exp_b[k]);
      end
    end
    wr_fifo_usedw = 11'd0;
    rd_enable = 1'b0;
    tick(3);
  endtask

  task automatic test_reset_mid();
    bit ok, is_wr, held, dropped, fd;
    logic [19:0] addr;
    logic [1:0] bank;
    int n;
    wr_fifo_usedw = 11'd256;
    n = 0;
    while (!write_req && n < 20) begin tick(1); n++; end
    checks++;
    if (write_req !== 1'b1 || sdram_addr !== 20'd512) begin
      errors++;
      $display("FAIL pre_reset_write: got wr=%b addr=%0d, expected 1 512", write_req, sdram_addr);
    end
    RST = 1'b1;
    tick(1);
    checks++;
    if ({write_req, read_req, sdram_addr, sys_bank, frame_done, busy} !== 26'd0) begin
      errors++;
      $display("FAIL reset_mid_burst: got wr=%b rd=%b addr=%0d bank=%0d busy=%b, expected all 0",
               write_req, read_req, sdram_addr, sys_bank, busy);
    end
    RST = 1'b0;
    wr_fifo_usedw = 11'd0;
    rd_enable = 1'b1;
    rd_fifo_usedw = 11'd0;
    tick(10);
    checks++;
    if (read_req !== 1'b0 || write_req !== 1'b0) begin
      errors++;
      $display("FAIL frame_valid_cleared: got rd=%b wr=%b, expected 0 0", read_req, write_req);
    end
    rd_enable = 1'b0;
    wr_fifo_usedw = 11'd256;
    serve(1'b0, ok, is_wr, addr, bank, held, dropped, fd);
    checks++;
    if (!ok || !is_wr || addr !== 20'd0 || bank !== 2'd0) begin
      errors++;
      $display("FAIL wr_ptr_cleared: got ok=%b wr=%b addr=%0d bank=%0d, expected 1 1 0 0", ok, is_wr, addr, bank);
    end
    wr_fifo_usedw = 11'd0;
    tick(3);
  endtask

  initial begin
    RST = 1'b1; wr_fifo_usedw = '0; rd_fifo_usedw = '0;
    rd_enable = 1'b0; write_ack = 1'b0; read_ack = 1'b0;
    test_reset();
    test_single_write();
    test_frame();
    test_tie_ack_hygiene();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
